// File: rtl/regfile_pkg.sv
// Shared defaults and snapshot state type for the ADC register file.
package regfile_pkg;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_ADDR_W       = 6;
    localparam int DEF_NUM_REGS     = 37;
    localparam int DEF_ADC_BASE     = 3;
    localparam int DEF_ADC_NUM      = 3;
    localparam int DEF_LOCK_TIMEOUT = 64;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } snap_state_t;
endpackage

// File: rtl/adc_snapshot_ctrl.sv
// Snapshot lock FSM: timeout counter, per-channel read tracking and sticky overrun flags.
module adc_snapshot_ctrl
    import regfile_pkg::*;
#(
    parameter int ADC_NUM      = DEF_ADC_NUM,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               snap,
    input  logic [ADC_NUM-1:0] rd_hit,
    input  logic [ADC_NUM-1:0] adc_valid,
    output logic               locked,
    output logic [ADC_NUM-1:0] ovr
);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT);

    snap_state_t        state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [ADC_NUM-1:0] rd_done_reg;
    logic [ADC_NUM-1:0] ovr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rd_done_reg <= '0;
            ovr_reg     <= '0;
        end else if (snap) begin
            // Channel 0 is consumed by the snapshot read itself.
            cnt_reg     <= '0;
            ovr_reg     <= '0;
            rd_done_reg <= ADC_NUM'(1);
            state_reg   <= (ADC_NUM > 1) ? LOCKED : IDLE;
        end else if (state_reg == LOCKED) begin
            ovr_reg     <= ovr_reg | (adc_valid & ~rd_done_reg);
            rd_done_reg <= rd_done_reg | rd_hit;
            if (rd_hit[ADC_NUM-1] || cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign locked = (state_reg == LOCKED);
    assign ovr    = ovr_reg;
endmodule

// File: rtl/regfile_snapshot.sv
// Register file with ADC-owned live registers and a coherent multi-channel snapshot on read.
module regfile_snapshot
    import regfile_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int ADC_BASE     = DEF_ADC_BASE,
    parameter int ADC_NUM      = DEF_ADC_NUM,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            Reg_write,
    input  logic                            Reg_read,
    input  logic [ADDR_W-1:0]               Reg_addr,
    input  logic [DATA_W-1:0]               Data_in,
    output logic [DATA_W-1:0]               Data_out,
    output logic                            Data_valid,
    input  logic [ADC_NUM-1:0]              adc_valid,
    input  logic [ADC_NUM-1:0][DATA_W-1:0]  adc_data,
    output logic                            wr_err,
    output logic [ADC_NUM-1:0]              adc_ovr,
    output logic                            snap_locked
);
    localparam int AW1 = ADDR_W + 1;
    localparam logic [ADDR_W:0] ADC_LO  = AW1'(ADC_BASE);
    localparam logic [ADDR_W:0] ADC_HI  = AW1'(ADC_BASE + ADC_NUM);
    localparam logic [ADDR_W:0] REG_END = AW1'(NUM_REGS);

    if (ADC_BASE + ADC_NUM > NUM_REGS) begin : g_err_range
        $error("ADC range exceeds implemented registers");
    end
    if (NUM_REGS > 2 ** ADDR_W) begin : g_err_addr
        $error("NUM_REGS does not fit in ADDR_W");
    end
    if (ADC_NUM < 1) begin : g_err_num
        $error("ADC_NUM must be at least 1");
    end
    if (LOCK_TIMEOUT < 2) begin : g_err_timeout
        $error("LOCK_TIMEOUT must be at least 2");
    end

    logic [ADDR_W:0]    addr_ext;
    logic               in_range;
    logic               in_adc;
    logic               wr_legal;
    logic               rd_en;
    logic               snap;
    logic [ADC_NUM-1:0] rd_hit;
    logic [DATA_W-1:0]  rd_value;
    logic [DATA_W-1:0]  live   [NUM_REGS];
    logic [DATA_W-1:0]  shadow [ADC_NUM];
    logic [DATA_W-1:0]  cap    [ADC_NUM];

    assign addr_ext = {1'b0, Reg_addr};
    assign in_range = addr_ext < REG_END;
    assign in_adc   = (addr_ext >= ADC_LO) && (addr_ext < ADC_HI);
    assign wr_legal = Reg_write && in_range && !in_adc;
    assign rd_en    = Reg_read && !Reg_write;
    assign snap     = rd_hit[0];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_W-1:0] value_reg;
        if (gi >= ADC_BASE && gi < ADC_BASE + ADC_NUM) begin : g_adc
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    value_reg <= '0;
                else if (adc_valid[gi-ADC_BASE])
                    value_reg <= adc_data[gi-ADC_BASE];
            end
        end else begin : g_sw
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    value_reg <= '0;
                else if (wr_legal && addr_ext == AW1'(gi))
                    value_reg <= Data_in;
            end
        end
        assign live[gi] = value_reg;
    end

    for (genvar gi = 0; gi < ADC_NUM; gi++) begin : g_ch
        logic [DATA_W-1:0] shadow_reg;
        // Snapshot sees this cycle's sample, matching what the live register is about to hold.
        assign cap[gi]    = adc_valid[gi] ? adc_data[gi] : live[ADC_BASE+gi];
        assign rd_hit[gi] = rd_en && (addr_ext == AW1'(ADC_BASE + gi));
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                shadow_reg <= '0;
            else if (snap)
                shadow_reg <= cap[gi];
        end
        assign shadow[gi] = shadow_reg;
    end

    always_comb begin
        rd_value = '0;
        if (in_range)
            rd_value = live[Reg_addr];
        for (int i = 0; i < ADC_NUM; i++) begin
            if (rd_hit[i]) begin
                if (i == 0)
                    rd_value = cap[i];
                else if (snap_locked)
                    rd_value = shadow[i];
                else
                    rd_value = live[ADC_BASE+i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Data_out   <= '0;
            Data_valid <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            Data_valid <= rd_en;
            wr_err     <= Reg_write && !wr_legal;
            if (rd_en)
                Data_out <= rd_value;
        end
    end

    adc_snapshot_ctrl #(
        .ADC_NUM      (ADC_NUM),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .snap      (snap),
        .rd_hit    (rd_hit),
        .adc_valid (adc_valid),
        .locked    (snap_locked),
        .ovr       (adc_ovr)
    );
endmodule

// File: tb/tb_regfile_snapshot.sv
// Directed checks of regfile_snapshot with hand-computed expectations.
module tb_regfile_snapshot;
    logic             clk = 1'b0;
    logic             rst_n;
    logic             Reg_write, Reg_read;
    logic [5:0]       Reg_addr;
    logic [7:0]       Data_in;
    logic [7:0]       Data_out;
    logic             Data_valid;
    logic [2:0]       adc_valid;
    logic [2:0][7:0]  adc_data;
    logic             wr_err;
    logic [2:0]       adc_ovr;
    logic             snap_locked;

    int errors = 0;
    int checks = 0;

    regfile_snapshot dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Reg_write   (Reg_write),
        .Reg_read    (Reg_read),
        .Reg_addr    (Reg_addr),
        .Data_in     (Data_in),
        .Data_out    (Data_out),
        .Data_valid  (Data_valid),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .wr_err      (wr_err),
        .adc_ovr     (adc_ovr),
        .snap_locked (snap_locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        Reg_write = 1'b0;
        Reg_read  = 1'b0;
        adc_valid = 3'b000;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        Reg_write = 1'b1; Reg_read = 1'b0; Reg_addr = a; Data_in = d;
        tick();
        Reg_write = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a);
        Reg_write = 1'b0; Reg_read = 1'b1; Reg_addr = a;
        tick();
        Reg_read = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, Data_valid, 1);
        check({tag, "_data"}, Data_out, exp);
    endtask

    initial begin
        rst_n = 1'b0; idle_in(); Reg_addr = '0; Data_in = '0; adc_data = '0;
        #2;
        check("rst_data_out", Data_out, 0);
        check("rst_valid", Data_valid, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_ovr", adc_ovr, 0);
        check("rst_locked", snap_locked, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        wr(6'd0, 8'hA5);
        rd(6'd0);
        check_read("rd0", 8'hA5);
        tick();
        check("rd0_valid_drop", Data_valid, 0);
        check("rd0_hold", Data_out, 8'hA5);

        wr(6'd4, 8'h55);
        check("wr4_err", wr_err, 1);
        tick();
        check("wr4_err_drop", wr_err, 0);
        rd(6'd4);
        check_read("rd4_unchanged", 8'h00);
        rd(6'd40);
        check_read("rd40", 8'h00);
        wr(6'd40, 8'h12);
        check("wr40_err", wr_err, 1);
        wr(6'd36, 8'h77);
        check("wr36_no_err", wr_err, 0);
        rd(6'd36);
        check_read("rd36", 8'h77);

        Reg_write = 1'b1; Reg_read = 1'b1; Reg_addr = 6'd1; Data_in = 8'h3C;
        tick();
        idle_in();
        check("wrrd_no_valid", Data_valid, 0);
        check("wrrd_hold", Data_out, 8'h77);
        rd(6'd1);
        check_read("rd1", 8'h3C);

        adc_valid = 3'b111; adc_data = {8'h30, 8'h20, 8'h10};
        tick();
        adc_valid = 3'b000;
        rd(6'd3);
        check_read("snap_rd3", 8'h10);
        check("snap_locked", snap_locked, 1);
        adc_valid = 3'b111; adc_data = {8'h31, 8'h21, 8'h11};
        tick();
        adc_valid = 3'b000;
        check("ovr_110", adc_ovr, 3'b110);
        rd(6'd4);
        check_read("shadow_rd4", 8'h20);
        check("still_locked", snap_locked, 1);
        rd(6'd5);
        check_read("shadow_rd5", 8'h30);
        check("unlock_last", snap_locked, 0);
        check("ovr_sticky", adc_ovr, 3'b110);
        rd(6'd4);
        check_read("live_rd4", 8'h21);

        adc_valid = 3'b001; adc_data = {8'h00, 8'h00, 8'h99};
        Reg_read = 1'b1; Reg_addr = 6'd3;
        tick();
        idle_in();
        check_read("snap_bypass", 8'h99);
        check("ovr_cleared", adc_ovr, 3'b000);
        rd(6'd5);
        check("unlock_again", snap_locked, 0);

        rd(6'd3);
        check("timeout_locked", snap_locked, 1);
        repeat (62) tick();
        check("timeout_before", snap_locked, 1);
        repeat (2) tick();
        check("timeout_after", snap_locked, 0);
        check("timeout_no_ovr", adc_ovr, 3'b000);
        adc_valid = 3'b010; adc_data = {8'h00, 8'h42, 8'h00};
        tick();
        adc_valid = 3'b000;
        check("idle_no_ovr", adc_ovr, 3'b000);
        rd(6'd4);
        check_read("timeout_live_rd4", 8'h42);

        rd(6'd3);
        check("prerst_locked", snap_locked, 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_locked", snap_locked, 0);
        check("arst_data_out", Data_out, 0);
        check("arst_valid", Data_valid, 0);
        check("arst_wr_err", wr_err, 0);
        check("arst_ovr", adc_ovr, 0);
        @(negedge clk); rst_n = 1'b1;
        adc_valid = 3'b010; adc_data = {8'h00, 8'h5A, 8'h00};
        tick();
        adc_valid = 3'b000;
        rd(6'd4);
        check_read("postrst_live_rd4", 8'h5A);
        rd(6'd0);
        check_read("postrst_rd0", 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
